audio_frame_sched: RTL and testbench
====================================

# audio_frame_sched

Stereo sample scheduler that sits in front of the I2S serializer. It generates the serializer's bit-clock enable and buffers samples from two audio sources (A and B) in small FIFOs. Once per I2S frame it pops one stereo sample from each source, mixes the pair with saturation and presents the result on the serializer's left/right inputs. Core sound drives source A; auxiliary sound (tape/disk clicks) drives source B.

## Interface
- AUDIO_DW, 16: sample width per channel, signed two's complement.
- CE_DIV, 4: clk cycles per serializer enable pulse; legal values ≥ 2.
- FIFO_DEPTH, 4: entries per source FIFO, power of two.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- a_valid  in  1  source A sample offered.
- a_ready  out  1  source A FIFO can accept a sample.
- a_left, a_right  in  AUDIO_DW each  source A sample.
- b_valid  in  1  source B sample offered.
- b_ready  out  1  source B FIFO can accept a sample.
- b_left, b_right  in  AUDIO_DW each  source B sample.
- i2s_ce  out  1  serializer enable, one-cycle pulse.
- left_chan, right_chan  out  AUDIO_DW each  mixed sample to the serializer.
- frame_tick  out  1  one-cycle pulse marking the sample-update point.
- underrun_a, underrun_b  out  1 each  one-cycle pulse when that source's FIFO was empty at frame_tick.

## Operation
- Enable divider: counter runs 0..CE_DIV-1. i2s_ce is high for exactly one cycle when the counter is CE_DIV-1.
- Frame counter: counts i2s_ce pulses, 0..4*AUDIO_DW-1. The serializer consumes one stereo pair per 4*AUDIO_DW enables.
- frame_tick goes high in the same cycle as the i2s_ce pulse that takes the frame counter from 4*AUDIO_DW-1 to 0.
- Source FIFOs: one per source, each entry {left,right}.
  - x_ready = !reset && count < FIFO_DEPTH.
  - A push occurs on the clk edge where x_valid && x_ready.
- On the frame_tick edge, for each source:
  - Non-empty FIFO: pop the head into that source's hold register.
  - Empty FIFO: keep the hold register unchanged and pulse underrun_x on the next cycle.
- Push and pop on the same edge: both take effect and the count is unchanged. Push while full cannot occur because ready is low.
- Mix: per channel, hold_A + hold_B computed at AUDIO_DW+1 bits, then clamped to [-2^(AUDIO_DW-1), 2^(AUDIO_DW-1)-1].
- left_chan/right_chan are registered. They take the mixed value of the hold registers as updated at frame_tick, one cycle after that frame_tick. They are stable at all other times.
- Reset values (asserted at any time, including mid-frame):
  - Both counters 0, FIFOs empty, hold registers 0.
  - left_chan = right_chan = 0.
  - i2s_ce, frame_tick, underrun_a, underrun_b = 0.
  - a_ready, b_ready = 0.

## Timing
- Cycle 1 is the first clk edge with reset low.
- First i2s_ce is high in cycle CE_DIV. Subsequent pulses every CE_DIV cycles.
- First frame_tick is in cycle 4*AUDIO_DW*CE_DIV. Period is 4*AUDIO_DW*CE_DIV cycles.
- Latency from frame_tick to new left_chan/right_chan: 1 cycle. underrun_x pulses in that same cycle.
- Latency from push to FIFO visibility: a sample pushed on the frame_tick edge into an empty FIFO is not popped until the next frame_tick.
- Ready becomes high the cycle after a pop frees an entry.

## Configuration
- AUDIO_SCHED_SRC_B_EN:
  - Defined: source B FIFO, hold register and mixer are present as above.
  - Undefined: b_ready is constant 0, b_valid/b_left/b_right are ignored, underrun_b is constant 0, and left_chan/right_chan equal hold_A directly (no saturation stage). Output latency is unchanged at 1 cycle after frame_tick.

## Test plan
- Reset then idle, AUDIO_DW=16, CE_DIV=4 -> i2s_ce every 4 cycles starting cycle 4; frame_tick in cycles 256, 512; outputs 0; underrun_a and underrun_b pulse at cycles 257, 513.
- Push A=(0x1000,0xF000) and B=(0x0100,0x0010) before cycle 256 -> cycle 257: left_chan=0x1100, right_chan=0xF010; no underrun.
- Saturation: A=(0x7000,0x9000), B=(0x2000,0xA000) -> left_chan=0x7FFF, right_chan=0x8000.
- Fill A with 4 samples -> a_ready low after the 4th push; high again the cycle after the next frame_tick. A 5th push attempted while a_ready is low is not accepted.
- A empty at frame_tick after previous value 0x1234/0x4321 with B holding 0 -> outputs stay 0x1234/0x4321 and underrun_a pulses once.
- Assert reset at cycle 130 with 2 samples queued -> outputs 0, FIFOs empty, first frame_tick 256 cycles after reset release.

Source files
------------

// File: rtl/audio_frame_sched_if.sv
// -----------------------------------------------------------------------------
// audio_frame_sched_if
// Bundles the audio source handshakes and the serializer-facing outputs of
// audio_frame_sched.
//   master : audio sources / serializer side (drives samples, sees outputs)
//   slave  : the scheduler itself
// Signals:
//   a_valid/a_ready/a_left/a_right  source A sample handshake
//   b_valid/b_ready/b_left/b_right  source B sample handshake
//   i2s_ce                          serializer enable pulse
//   left_chan/right_chan            mixed sample to the serializer
//   frame_tick                      sample-update pulse
//   underrun_a/underrun_b           per-source empty-at-frame pulse
// -----------------------------------------------------------------------------
interface audio_frame_sched_if #(
    parameter int AUDIO_DW = 16
);
    logic                a_valid;
    logic                a_ready;
    logic [AUDIO_DW-1:0] a_left;
    logic [AUDIO_DW-1:0] a_right;
    logic                b_valid;
    logic                b_ready;
    logic [AUDIO_DW-1:0] b_left;
    logic [AUDIO_DW-1:0] b_right;
    logic                i2s_ce;
    logic [AUDIO_DW-1:0] left_chan;
    logic [AUDIO_DW-1:0] right_chan;
    logic                frame_tick;
    logic                underrun_a;
    logic                underrun_b;

    modport master (
        output a_valid, a_left, a_right, b_valid, b_left, b_right,
        input  a_ready, b_ready, i2s_ce, left_chan, right_chan,
               frame_tick, underrun_a, underrun_b
    );

    modport slave (
        input  a_valid, a_left, a_right, b_valid, b_left, b_right,
        output a_ready, b_ready, i2s_ce, left_chan, right_chan,
               frame_tick, underrun_a, underrun_b
    );
endinterface

// File: rtl/audio_frame_sched.sv
// -----------------------------------------------------------------------------
// audio_frame_sched
// Stereo sample scheduler in front of the I2S serializer. Divides clk into the
// serializer enable, counts enables into frames, buffers samples from two
// sources in small FIFOs and, once per frame, pops one stereo pair from each
// source, mixes them with saturation and registers the result for the
// serializer.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    audio_frame_sched_if.slave (source handshakes, serializer outputs)
// Build option:
//   AUDIO_SCHED_SRC_B_EN  defined   -> source B FIFO, hold register and
//                                      saturating mixer present
//                         undefined -> source B ignored, outputs = hold A
// -----------------------------------------------------------------------------
module audio_frame_sched #(
    parameter int AUDIO_DW   = 16,
    parameter int CE_DIV     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    audio_frame_sched_if.slave        bus
);
    localparam int DIV_W = $clog2(CE_DIV);
    localparam int FRM_W = $clog2(4 * AUDIO_DW);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(4 * AUDIO_DW - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // FIFO entry / hold register layout: {left, right}
    typedef logic [2*AUDIO_DW-1:0] entry_t;

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [FRM_W-1:0]    frm_cnt_q, frm_cnt_d;
    logic                i2s_ce;
    logic                frame_tick;

    entry_t              a_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    a_wr_ptr_q, a_wr_ptr_d;
    logic [PTR_W-1:0]    a_rd_ptr_q, a_rd_ptr_d;
    logic [CNT_W-1:0]    a_cnt_q, a_cnt_d;
    logic                a_ready, a_push, a_pop, a_empty;
    entry_t              hold_a_q, hold_a_d;
    logic                underrun_a_q, underrun_a_d;

    logic [AUDIO_DW-1:0] left_q, left_d;
    logic [AUDIO_DW-1:0] right_q, right_d;

    // Enable divider and frame counter. Both strobes are gated by reset so the
    // outputs read 0 during reset even before the counters have cleared.
    always_comb begin
        i2s_ce     = !reset && (div_cnt_q == DIV_LAST);
        frame_tick = i2s_ce && (frm_cnt_q == FRM_LAST);
        div_cnt_d  = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        frm_cnt_d  = frm_cnt_q;
        if (i2s_ce) begin
            frm_cnt_d = (frm_cnt_q == FRM_LAST) ? '0 : frm_cnt_q + FRM_W'(1);
        end
    end

    // Source A FIFO. The pop reads the head before this edge's push lands, so
    // a sample pushed into an empty FIFO on the frame edge waits a full frame.
    always_comb begin
        a_ready    = !reset && (a_cnt_q != CNT_FULL);
        a_push     = bus.a_valid && a_ready;
        a_empty    = (a_cnt_q == '0);
        a_pop      = frame_tick && !a_empty;
        a_wr_ptr_d = a_wr_ptr_q;
        if (a_push) begin
            a_wr_ptr_d = (a_wr_ptr_q == PTR_LAST) ? '0 : a_wr_ptr_q + PTR_W'(1);
        end
        a_rd_ptr_d = a_rd_ptr_q;
        if (a_pop) begin
            a_rd_ptr_d = (a_rd_ptr_q == PTR_LAST) ? '0 : a_rd_ptr_q + PTR_W'(1);
        end
        a_cnt_d = a_cnt_q;
        if (a_push && !a_pop) begin
            a_cnt_d = a_cnt_q + CNT_W'(1);
        end else if (a_pop && !a_push) begin
            a_cnt_d = a_cnt_q - CNT_W'(1);
        end
        hold_a_d     = a_pop ? a_mem_q[a_rd_ptr_q] : hold_a_q;
        underrun_a_d = frame_tick && a_empty;
    end

    always_ff @(posedge clk) begin
        if (a_push) begin
            a_mem_q[a_wr_ptr_q] <= {bus.a_left, bus.a_right};
        end
    end

`ifdef AUDIO_SCHED_SRC_B_EN
    localparam logic signed [AUDIO_DW-1:0] SAT_MAX = {1'b0, {(AUDIO_DW-1){1'b1}}};
    localparam logic signed [AUDIO_DW-1:0] SAT_MIN = {1'b1, {(AUDIO_DW-1){1'b0}}};

    // One guard bit is enough for the sum of two samples; overflow shows up
    // as the guard bit disagreeing with the sample sign bit.
    function automatic logic signed [AUDIO_DW-1:0] sat_add(
        input logic signed [AUDIO_DW-1:0] x,
        input logic signed [AUDIO_DW-1:0] y
    );
        logic signed [AUDIO_DW:0] sum;
        sum = $signed({x[AUDIO_DW-1], x}) + $signed({y[AUDIO_DW-1], y});
        if (sum[AUDIO_DW] != sum[AUDIO_DW-1]) begin
            sat_add = sum[AUDIO_DW] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_add = sum[AUDIO_DW-1:0];
        end
    endfunction

    entry_t              b_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    b_wr_ptr_q, b_wr_ptr_d;
    logic [PTR_W-1:0]    b_rd_ptr_q, b_rd_ptr_d;
    logic [CNT_W-1:0]    b_cnt_q, b_cnt_d;
    logic                b_ready, b_push, b_pop, b_empty;
    entry_t              hold_b_q, hold_b_d;
    logic                underrun_b_q, underrun_b_d;

    // Source B FIFO, same behaviour as source A.
    always_comb begin
        b_ready    = !reset && (b_cnt_q != CNT_FULL);
        b_push     = bus.b_valid && b_ready;
        b_empty    = (b_cnt_q == '0);
        b_pop      = frame_tick && !b_empty;
        b_wr_ptr_d = b_wr_ptr_q;
        if (b_push) begin
            b_wr_ptr_d = (b_wr_ptr_q == PTR_LAST) ? '0 : b_wr_ptr_q + PTR_W'(1);
        end
        b_rd_ptr_d = b_rd_ptr_q;
        if (b_pop) begin
            b_rd_ptr_d = (b_rd_ptr_q == PTR_LAST) ? '0 : b_rd_ptr_q + PTR_W'(1);
        end
        b_cnt_d = b_cnt_q;
        if (b_push && !b_pop) begin
            b_cnt_d = b_cnt_q + CNT_W'(1);
        end else if (b_pop && !b_push) begin
            b_cnt_d = b_cnt_q - CNT_W'(1);
        end
        hold_b_d     = b_pop ? b_mem_q[b_rd_ptr_q] : hold_b_q;
        underrun_b_d = frame_tick && b_empty;
    end

    always_ff @(posedge clk) begin
        if (b_push) begin
            b_mem_q[b_wr_ptr_q] <= {bus.b_left, bus.b_right};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b_wr_ptr_q   <= '0;
            b_rd_ptr_q   <= '0;
            b_cnt_q      <= '0;
            hold_b_q     <= '0;
            underrun_b_q <= 1'b0;
        end else begin
            b_wr_ptr_q   <= b_wr_ptr_d;
            b_rd_ptr_q   <= b_rd_ptr_d;
            b_cnt_q      <= b_cnt_d;
            hold_b_q     <= hold_b_d;
            underrun_b_q <= underrun_b_d;
        end
    end

    assign bus.b_ready    = b_ready;
    assign bus.underrun_b = underrun_b_q;

    // Mix from the post-pop hold values so the new pair appears one cycle
    // after frame_tick.
    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        if (frame_tick) begin
            left_d  = sat_add(hold_a_d[2*AUDIO_DW-1:AUDIO_DW], hold_b_d[2*AUDIO_DW-1:AUDIO_DW]);
            right_d = sat_add(hold_a_d[AUDIO_DW-1:0], hold_b_d[AUDIO_DW-1:0]);
        end
    end
`else
    logic unused_b_inputs;
    assign unused_b_inputs = ^{bus.b_valid, bus.b_left, bus.b_right};

    assign bus.b_ready    = 1'b0;
    assign bus.underrun_b = 1'b0;

    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        if (frame_tick) begin
            left_d  = hold_a_d[2*AUDIO_DW-1:AUDIO_DW];
            right_d = hold_a_d[AUDIO_DW-1:0];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            frm_cnt_q    <= '0;
            a_wr_ptr_q   <= '0;
            a_rd_ptr_q   <= '0;
            a_cnt_q      <= '0;
            hold_a_q     <= '0;
            underrun_a_q <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            frm_cnt_q    <= frm_cnt_d;
            a_wr_ptr_q   <= a_wr_ptr_d;
            a_rd_ptr_q   <= a_rd_ptr_d;
            a_cnt_q      <= a_cnt_d;
            hold_a_q     <= hold_a_d;
            underrun_a_q <= underrun_a_d;
            left_q       <= left_d;
            right_q      <= right_d;
        end
    end

    assign bus.a_ready    = a_ready;
    assign bus.i2s_ce     = i2s_ce;
    assign bus.frame_tick = frame_tick;
    assign bus.underrun_a = underrun_a_q;
    assign bus.left_chan  = left_q;
    assign bus.right_chan = right_q;
endmodule

// File: tb/tb_audio_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_audio_frame_sched
// Directed and randomized stimulus for audio_frame_sched, checked every cycle
// against a frame-level reference model built from queues and plain integer
// arithmetic. Follows AUDIO_SCHED_SRC_B_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_audio_frame_sched;
    localparam int DW     = 16;
    localparam int CE_DIV = 4;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 4 * DW * CE_DIV;
`ifdef AUDIO_SCHED_SRC_B_EN
    localparam bit B_EN = 1'b1;
`else
    localparam bit B_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    audio_frame_sched_if #(.AUDIO_DW(DW)) bus ();

    audio_frame_sched #(
        .AUDIO_DW   (DW),
        .CE_DIV     (CE_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [2*DW-1:0] qa[$];
    logic [2*DW-1:0] qb[$];
    logic [2*DW-1:0] hold_a, hold_b;
    logic [DW-1:0]   exp_left, exp_right;
    logic            exp_und_a, exp_und_b;
    int              cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc + 1);
        end
    endtask

    function automatic logic [DW-1:0] mix(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int s;
        int hi;
        int lo;
        if (!B_EN) return a;
        hi = (1 << (DW - 1)) - 1;
        lo = -(1 << (DW - 1));
        s = int'($signed(a)) + int'($signed(b));
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
        return s[DW-1:0];
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        hold_a    = '0;
        hold_b    = '0;
        exp_left  = '0;
        exp_right = '0;
        exp_und_a = 1'b0;
        exp_und_b = 1'b0;
        cyc       = 0;
    endtask

    // One clock cycle: check the outputs expected for cycle cyc+1, drive
    // inputs, take the edge, advance the model. Entered and left at negedge.
    task automatic step(input logic av, input logic [DW-1:0] al, input logic [DW-1:0] ar,
                        input logic bv, input logic [DW-1:0] bl, input logic [DW-1:0] br);
        int   k;
        logic ft, rdy_a, rdy_b;
        #1;
        k     = cyc + 1;
        ft    = (k % FRAME) == 0;
        rdy_a = qa.size() < DEPTH;
        rdy_b = B_EN && (qb.size() < DEPTH);
        check("i2s_ce",     32'(bus.i2s_ce),     32'((k % CE_DIV) == 0));
        check("frame_tick", 32'(bus.frame_tick), 32'(ft));
        check("a_ready",    32'(bus.a_ready),    32'(rdy_a));
        check("b_ready",    32'(bus.b_ready),    32'(rdy_b));
        check("underrun_a", 32'(bus.underrun_a), 32'(exp_und_a));
        check("underrun_b", 32'(bus.underrun_b), 32'(exp_und_b));
        check("left_chan",  32'(bus.left_chan),  32'(exp_left));
        check("right_chan", 32'(bus.right_chan), 32'(exp_right));
        bus.a_valid = av;
        bus.a_left  = al;
        bus.a_right = ar;
        bus.b_valid = bv;
        bus.b_left  = bl;
        bus.b_right = br;
        @(posedge clk);
        exp_und_a = 1'b0;
        exp_und_b = 1'b0;
        if (ft) begin
            if (qa.size() > 0) hold_a = qa.pop_front();
            else exp_und_a = 1'b1;
            if (B_EN) begin
                if (qb.size() > 0) hold_b = qb.pop_front();
                else exp_und_b = 1'b1;
            end
            exp_left  = mix(hold_a[2*DW-1:DW], hold_b[2*DW-1:DW]);
            exp_right = mix(hold_a[DW-1:0], hold_b[DW-1:0]);
        end
        if (av && rdy_a) qa.push_back({al, ar});
        if (bv && rdy_b) qb.push_back({bl, br});
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic run_until(input int target);
        while (cyc < target) idle();
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_a_ready",    32'(bus.a_ready),    32'h0);
        check("rst_b_ready",    32'(bus.b_ready),    32'h0);
        check("rst_i2s_ce",     32'(bus.i2s_ce),     32'h0);
        check("rst_frame_tick", 32'(bus.frame_tick), 32'h0);
        check("rst_underrun_a", 32'(bus.underrun_a), 32'h0);
        check("rst_underrun_b", 32'(bus.underrun_b), 32'h0);
        check("rst_left",       32'(bus.left_chan),  32'h0);
        check("rst_right",      32'(bus.right_chan), 32'h0);
        model_clear();
        reset = 1'b0;
    endtask

    initial begin
        bus.a_valid = 1'b0;
        bus.a_left  = '0;
        bus.a_right = '0;
        bus.b_valid = 1'b0;
        bus.b_left  = '0;
        bus.b_right = '0;
        model_clear();

        // Reset then idle: first frame at 256, underruns at 257
        do_reset(3);
        run_until(255);
        check("first_frame_tick", 32'(bus.frame_tick), 32'h1);
        run_until(256);
        check("idle_underrun_a", 32'(bus.underrun_a), 32'h1);
        check("idle_underrun_b", 32'(bus.underrun_b), 32'(B_EN));
        check("idle_left",       32'(bus.left_chan),  32'h0);
        run_until(513);

        // Plain mix
        step(1'b1, 16'h1000, 16'hF000, 1'b1, 16'h0100, 16'h0010);
        run_until(768);
        check("mix_left",  32'(bus.left_chan),  B_EN ? 32'h1100 : 32'h1000);
        check("mix_right", 32'(bus.right_chan), B_EN ? 32'hF010 : 32'hF000);
        check("mix_no_underrun", 32'(bus.underrun_a), 32'h0);

        // Saturation both directions
        step(1'b1, 16'h7000, 16'h9000, 1'b1, 16'h2000, 16'hA000);
        run_until(1024);
        check("sat_left",  32'(bus.left_chan),  B_EN ? 32'h7FFF : 32'h7000);
        check("sat_right", 32'(bus.right_chan), B_EN ? 32'h8000 : 32'h9000);

        // Fill A, B gets a single zero sample
        step(1'b1, 16'h0111, 16'h0222, 1'b1, 16'h0000, 16'h0000);
        step(1'b1, 16'h0333, 16'h0444, 1'b0, '0, '0);
        step(1'b1, 16'h0555, 16'h0666, 1'b0, '0, '0);
        step(1'b1, 16'h1234, 16'h4321, 1'b0, '0, '0);
        check("full_ready_low", 32'(bus.a_ready), 32'h0);
        repeat (3) step(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, '0, '0);
        check("full_ready_still_low", 32'(bus.a_ready), 32'h0);
        run_until(1279);
        check("ready_before_pop", 32'(bus.a_ready), 32'h0);
        run_until(1280);
        check("ready_after_pop", 32'(bus.a_ready), 32'h1);
        check("first_fill_left", 32'(bus.left_chan), 32'h0111);

        // Drain, then an empty frame keeps 0x1234/0x4321
        run_until(2304);
        check("hold_left",  32'(bus.left_chan),  32'h1234);
        check("hold_right", 32'(bus.right_chan), 32'h4321);
        check("hold_underrun_a", 32'(bus.underrun_a), 32'h1);
        idle();
        check("underrun_a_single", 32'(bus.underrun_a), 32'h0);
        check("hold_left_stable",  32'(bus.left_chan),  32'h1234);

        // Randomized traffic over three frames
        repeat (3 * FRAME) begin
            step($urandom_range(0, 7) == 0, DW'($urandom), DW'($urandom),
                 $urandom_range(0, 7) == 0, DW'($urandom), DW'($urandom));
        end

        // Mid-frame reset with two samples queued
        do_reset(2);
        step(1'b1, DW'($urandom), DW'($urandom), 1'b1, DW'($urandom), DW'($urandom));
        step(1'b1, DW'($urandom), DW'($urandom), 1'b1, DW'($urandom), DW'($urandom));
        run_until(129);
        do_reset(3);
        run_until(255);
        check("post_reset_frame_tick", 32'(bus.frame_tick), 32'h1);
        run_until(256);
        check("post_reset_underrun_a", 32'(bus.underrun_a), 32'h1);
        check("post_reset_left",  32'(bus.left_chan),  32'h0);
        check("post_reset_right", 32'(bus.right_chan), 32'h0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
